// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_DRAIN    = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_RSVD     = 2'd3
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard terms: load-use against the instruction in ID, and taken branch/jump.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [4:0] IFID_rs_i,
  input  logic [4:0] IFID_rt_i,
  input  logic [4:0] IDEX_rt_i,
  input  logic       IDEX_MemRd_i,
  input  logic       Branch_i,
  input  logic       Jump_i,
  output logic       lu_o,
  output logic       flush_o
);

  // $zero is never a real producer, so it cannot create a load-use dependency.
  assign lu_o = IDEX_MemRd_i & (IDEX_rt_i != REG_ZERO) &
                ((IDEX_rt_i == IFID_rs_i) | (IDEX_rt_i == IFID_rt_i));

  assign flush_o = Branch_i | Jump_i;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: post-reset drain, load-use bubbles, branch flush, mem wait.
// Optional HAZARD_STATS_EN adds stall/flush event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned MAX_WAIT  = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  IFID_rs_i,
  input  logic [4:0]  IFID_rt_i,
  input  logic [4:0]  IDEX_rt_i,
  input  logic        IDEX_MemRd_i,
  input  logic        Branch_i,
  input  logic        Jump_i,
  input  logic        mem_busy_i,
  output logic        NoOp_o,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        IFIDFlush_o,
  output logic        PipeStall_o,
  output logic        timeout_o,
  output logic [1:0]  state_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int unsigned DrainW = $clog2(DRAIN_CYC + 1);

  state_e            state_q, state_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic              lu, flush;
  logic              in_run;

  hazard_detect u_detect (
    .IFID_rs_i    (IFID_rs_i),
    .IFID_rt_i    (IFID_rt_i),
    .IDEX_rt_i    (IDEX_rt_i),
    .IDEX_MemRd_i (IDEX_MemRd_i),
    .Branch_i     (Branch_i),
    .Jump_i       (Jump_i),
    .lu_o         (lu),
    .flush_o      (flush)
  );

  assign in_run = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mem_busy_i) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_busy_i) begin
          if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) timeout_d = 1'b1;
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        // The unused encoding behaves as DRAIN and falls back into it.
        state_d     = ST_DRAIN;
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (drain_cnt_q == DrainW'(DRAIN_CYC - 1)) begin
          state_d     = ST_RUN;
          drain_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_DRAIN;
      drain_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    NoOp_o      = 1'b0;
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    IFIDFlush_o = 1'b0;
    PipeStall_o = 1'b0;
    if (rst_i) begin
      NoOp_o      = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      IFIDFlush_o = 1'b1;
    end else if (in_run) begin
      if (mem_busy_i) begin
        PipeStall_o = 1'b1;
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
      end else if (lu) begin
        // A branch/jump in ID is held and re-evaluated once the bubble clears.
        NoOp_o      = 1'b1;
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
      end else if (flush) begin
        IFIDFlush_o = 1'b1;
      end
    end else begin
      NoOp_o = 1'b1;
    end
  end

  assign timeout_o = timeout_q;
  assign state_o   = state_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (in_run && !PCWrite_o) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (IFIDFlush_o) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; control bus packed as {NoOp,PCW,IFIDW,Flush,Stall}.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       idex_memrd, branch, jump, mem_busy;
  logic       noop, pcwrite, ifidwrite, ifidflush, pipestall, timeout;
  logic [1:0] state;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(
    .DRAIN_CYC (3),
    .MAX_WAIT  (16),
    .CNT_W     (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .IFID_rs_i    (ifid_rs),
    .IFID_rt_i    (ifid_rt),
    .IDEX_rt_i    (idex_rt),
    .IDEX_MemRd_i (idex_memrd),
    .Branch_i     (branch),
    .Jump_i       (jump),
    .mem_busy_i   (mem_busy),
    .NoOp_o       (noop),
    .PCWrite_o    (pcwrite),
    .IFIDWrite_o  (ifidwrite),
    .IFIDFlush_o  (ifidflush),
    .PipeStall_o  (pipestall),
    .timeout_o    (timeout),
    .state_o      (state)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt_o  (stall_cnt),
    .flush_cnt_o  (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [4:0] ctl = {noop, pcwrite, ifidwrite, ifidflush, pipestall};

  localparam logic [4:0] CtlRst   = 5'b10010;
  localparam logic [4:0] CtlDrain = 5'b11100;
  localparam logic [4:0] CtlRun   = 5'b01100;
  localparam logic [4:0] CtlLu    = 5'b10000;
  localparam logic [4:0] CtlFlush = 5'b01110;
  localparam logic [4:0] CtlBusy  = 5'b00001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to mid-cycle sampling point, then to just after the next edge.
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
    idex_memrd = 1'b0; branch = 1'b0; jump = 1'b0; mem_busy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    sample();
    chk("rst_ctl", 32'(ctl), 32'(CtlRst));
    next();
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      sample();
      chk("drain_ctl", 32'(ctl), 32'(CtlDrain));
      chk("drain_state", 32'(state), 32'd0);
      next();
    end
    sample();
    chk("run_state", 32'(state), 32'd1);
    chk("run_ctl", 32'(ctl), 32'(CtlRun));
    next();

    // Load-use via rt
    idex_memrd = 1'b1; idex_rt = 5'd8; ifid_rt = 5'd8;
    sample();
    chk("lu_rt", 32'(ctl), 32'(CtlLu));
    next();
    idle();
    sample();
    chk("lu_after", 32'(ctl), 32'(CtlRun));
    next();

    // Load-use via rs
    idex_memrd = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd9;
    sample();
    chk("lu_rs", 32'(ctl), 32'(CtlLu));
    next();

    // $zero never stalls
    idle();
    idex_memrd = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
    sample();
    chk("lu_zero", 32'(ctl), 32'(CtlRun));
    next();

    // Non-load producer never stalls
    idle();
    idex_rt = 5'd7; ifid_rs = 5'd7;
    sample();
    chk("no_memrd", 32'(ctl), 32'(CtlRun));
    next();

    // Load-use beats branch, then branch alone flushes
    idle();
    idex_memrd = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd3; branch = 1'b1;
    sample();
    chk("lu_over_br", 32'(ctl), 32'(CtlLu));
    next();
    idle();
    branch = 1'b1;
    sample();
    chk("br_flush", 32'(ctl), 32'(CtlFlush));
    next();
    idle();
    jump = 1'b1;
    sample();
    chk("j_flush", 32'(ctl), 32'(CtlFlush));
    next();

    // Mem busy 5 cycles with a branch pending; busy dominates
    idle();
    mem_busy = 1'b1; branch = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      sample();
      chk("busy5_ctl", 32'(ctl), 32'(CtlBusy));
      chk("busy5_state", 32'(state), (i == 1) ? 32'd1 : 32'd2);
      chk("busy5_to", 32'(timeout), 32'd0);
      next();
    end
    mem_busy = 1'b0;
    sample();
    chk("wait_exit_state", 32'(state), 32'd2);
    chk("wait_exit_ctl", 32'(ctl), 32'(CtlFlush));
    next();
    idle();
    sample();
    chk("back_run", 32'(state), 32'd1);
    chk("busy5_to_end", 32'(timeout), 32'd0);
    next();

    // Mem busy 20 cycles: timeout visible from the 17th busy cycle on
    mem_busy = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      sample();
      chk("busy20_to", 32'(timeout), (i >= 17) ? 32'd1 : 32'd0);
      chk("busy20_ctl", 32'(ctl), 32'(CtlBusy));
      next();
    end
    mem_busy = 1'b0;
    sample();
    chk("to_sticky0", 32'(timeout), 32'd1);
    next();
    sample();
    chk("to_sticky1", 32'(timeout), 32'd1);
    chk("to_run", 32'(state), 32'd1);
    next();

    // Reset mid-wait
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) next();
    sample();
    chk("midwait_state", 32'(state), 32'd2);
    next();
    rst = 1'b1;
    sample();
    chk("midwait_rst_ctl", 32'(ctl), 32'(CtlRst));
    next();
    rst = 1'b0;
    mem_busy = 1'b0;
    sample();
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_to", 32'(timeout), 32'd0);
    chk("post_rst_ctl", 32'(ctl), 32'(CtlDrain));
    next();
    next();
    next();
    sample();
    chk("redrain_run", 32'(state), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
